// File: rtl/rat_pkg.sv
// ---------------------------------------------------------------------------
// rat_pkg
// Shared definitions for the branch sequencer and its flag unit:
//   - state_e       : sequencer FSM state encoding
//   - PC_SEL_*      : PC_MUX_SEL source codes
//   - BRN_*         : COND_BRN_TYPE condition codes
//   - branchTaken() : conditional-branch evaluation against the flags
// ---------------------------------------------------------------------------
package rat_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXEC    = 2'b01,
    ST_INTR    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  localparam logic [1:0] PC_SEL_IMM    = 2'b00;
  localparam logic [1:0] PC_SEL_STACK  = 2'b01;
  localparam logic [1:0] PC_SEL_INTVEC = 2'b10;

  localparam logic [1:0] BRN_CC = 2'b00;
  localparam logic [1:0] BRN_CS = 2'b01;
  localparam logic [1:0] BRN_EQ = 2'b10;
  localparam logic [1:0] BRN_NE = 2'b11;

  // Decide whether a conditional branch of the given type is taken
  function automatic logic branchTaken(input logic [1:0] brnType,
                                       input logic       cFlag,
                                       input logic       zFlag);
    logic taken;
    taken = 1'b0;
    case (brnType)
      BRN_CC:  taken = ~cFlag;
      BRN_CS:  taken = cFlag;
      BRN_EQ:  taken = zFlag;
      BRN_NE:  taken = ~zFlag;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/flag_unit.sv
// ---------------------------------------------------------------------------
// flag_unit
// Holds the C, Z and I flags plus the C/Z shadow copies that carry the
// flags across an interrupt.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_update         : an executed instruction retires on this edge
//   i_intrEntry      : the interrupt-entry cycle ends on this edge
//   i_reti           : instruction is RETI (restore flags, re-enable I)
//   i_cIn, i_zIn     : ALU carry / zero results
//   i_cLd, i_zLd     : load C / Z from the ALU
//   i_cSet, i_cClr   : set / clear C
//   i_sei, i_cli     : set / clear I
//   o_cFlag, o_zFlag, o_iFlag : registered flags
// ---------------------------------------------------------------------------
module flag_unit
  import rat_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_update,
  input  logic i_intrEntry,
  input  logic i_reti,
  input  logic i_cIn,
  input  logic i_zIn,
  input  logic i_cLd,
  input  logic i_zLd,
  input  logic i_cSet,
  input  logic i_cClr,
  input  logic i_sei,
  input  logic i_cli,
  output logic o_cFlag,
  output logic o_zFlag,
  output logic o_iFlag
);

  logic r_cFlag;
  logic r_zFlag;
  logic r_iFlag;
  logic r_shadowC;
  logic r_shadowZ;

  // Interrupt entry snapshots C/Z and masks further interrupts; otherwise a
  // retiring instruction updates each flag by its own priority chain, with
  // RETI restoring the snapshot ahead of any explicit flag operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cFlag   <= 1'b0;
      r_zFlag   <= 1'b0;
      r_iFlag   <= 1'b0;
      r_shadowC <= 1'b0;
      r_shadowZ <= 1'b0;
    end else if (i_intrEntry) begin
      r_shadowC <= r_cFlag;
      r_shadowZ <= r_zFlag;
      r_iFlag   <= 1'b0;
    end else if (i_update) begin
      if (i_reti) begin
        r_cFlag <= r_shadowC;
      end else if (i_cClr) begin
        r_cFlag <= 1'b0;
      end else if (i_cSet) begin
        r_cFlag <= 1'b1;
      end else if (i_cLd) begin
        r_cFlag <= i_cIn;
      end

      if (i_reti) begin
        r_zFlag <= r_shadowZ;
      end else if (i_zLd) begin
        r_zFlag <= i_zIn;
      end

      if (i_reti) begin
        r_iFlag <= 1'b1;
      end else if (i_cli) begin
        r_iFlag <= 1'b0;
      end else if (i_sei) begin
        r_iFlag <= 1'b1;
      end
    end
  end

  assign o_cFlag = r_cFlag;
  assign o_zFlag = r_zFlag;
  assign o_iFlag = r_iFlag;

endmodule

// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
// Fetch/execute/interrupt sequencer that drives the PC controls and owns the
// branch decision. Flags live in flag_unit.
// Parameter:
//   INT_VEC_SEL : PC_MUX_SEL code used to select the interrupt vector
// Ports:
//   CLK, RST_N            : clock, asynchronous active-low reset
//   INSTR_VALID           : decoded instruction present in EXEC
//   COND_BRN, COND_BRN_TYPE, JMP, CALL, RET, RETI : branch class
//   INT_REQ               : level interrupt request (held until INT_ACK)
//   C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLR, SEI, CLI : flag operations
//   C_FLAG, Z_FLAG, I_FLAG: registered flags
//   PC_INC, PC_LD, PC_MUX_SEL : PC controls
//   INT_ACK               : interrupt being taken this cycle
//   STATE                 : current FSM state
// ---------------------------------------------------------------------------
module branch_sequencer
  import rat_pkg::*;
#(
  parameter logic [1:0] INT_VEC_SEL = PC_SEL_INTVEC
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       INSTR_VALID,
  input  logic       COND_BRN,
  input  logic [1:0] COND_BRN_TYPE,
  input  logic       JMP,
  input  logic       CALL,
  input  logic       RET,
  input  logic       RETI,
  input  logic       INT_REQ,
  input  logic       C_IN,
  input  logic       Z_IN,
  input  logic       C_LD,
  input  logic       Z_LD,
  input  logic       C_SET,
  input  logic       C_CLR,
  input  logic       SEI,
  input  logic       CLI,
  output logic       C_FLAG,
  output logic       Z_FLAG,
  output logic       I_FLAG,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic [1:0] PC_MUX_SEL,
  output logic       INT_ACK,
  output logic [1:0] STATE
);

  state_e r_state;
  state_e w_nextState;

  logic w_cFlag;
  logic w_zFlag;
  logic w_iFlag;
  logic w_execValid;
  logic w_intrEntry;
  logic w_condTaken;

  assign w_execValid = (r_state == ST_EXEC) && INSTR_VALID;
  assign w_intrEntry = (r_state == ST_INTR);

  // Uses the flags as they stand before this cycle's update
  assign w_condTaken = branchTaken(COND_BRN_TYPE, w_cFlag, w_zFlag);

  flag_unit u_flagUnit (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_update    (w_execValid),
    .i_intrEntry (w_intrEntry),
    .i_reti      (RETI),
    .i_cIn       (C_IN),
    .i_zIn       (Z_IN),
    .i_cLd       (C_LD),
    .i_zLd       (Z_LD),
    .i_cSet      (C_SET),
    .i_cClr      (C_CLR),
    .i_sei       (SEI),
    .i_cli       (CLI),
    .o_cFlag     (w_cFlag),
    .o_zFlag     (w_zFlag),
    .o_iFlag     (w_iFlag)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. The interrupt test uses the pre-update I flag, so a
  // SEI in the same instruction cannot admit a pending request.
  always_comb begin
    w_nextState = ST_FETCH;
    case (r_state)
      ST_FETCH: w_nextState = ST_EXEC;
      ST_EXEC: begin
        if (!INSTR_VALID) begin
          w_nextState = ST_EXEC;
        end else if (INT_REQ && w_iFlag) begin
          w_nextState = ST_INTR;
        end else begin
          w_nextState = ST_FETCH;
        end
      end
      ST_INTR:    w_nextState = ST_FETCH;
      ST_ILLEGAL: w_nextState = ST_FETCH;
      default:    w_nextState = ST_FETCH;
    endcase
  end

  // Output logic. Commands are qualified by RST_N so nothing is issued
  // while reset is held, even though the state already reads FETCH.
  always_comb begin
    PC_INC     = 1'b0;
    PC_LD      = 1'b0;
    PC_MUX_SEL = PC_SEL_IMM;
    INT_ACK    = 1'b0;
    if (RST_N) begin
      case (r_state)
        ST_FETCH: PC_INC = 1'b1;
        ST_EXEC: begin
          if (INSTR_VALID) begin
            if (RET || RETI) begin
              PC_LD      = 1'b1;
              PC_MUX_SEL = PC_SEL_STACK;
            end else if (JMP || CALL) begin
              PC_LD      = 1'b1;
              PC_MUX_SEL = PC_SEL_IMM;
            end else if (COND_BRN && w_condTaken) begin
              PC_LD      = 1'b1;
              PC_MUX_SEL = PC_SEL_IMM;
            end
          end
        end
        ST_INTR: begin
          PC_LD      = 1'b1;
          PC_MUX_SEL = INT_VEC_SEL;
          INT_ACK    = 1'b1;
        end
        default: begin
          PC_INC = 1'b0;
        end
      endcase
    end
  end

  assign C_FLAG = w_cFlag;
  assign Z_FLAG = w_zFlag;
  assign I_FLAG = w_iFlag;
  assign STATE  = r_state;

endmodule

// File: tb/tb_branch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_sequencer
// Directed, table-driven bench for branch_sequencer. Each table record holds
// one EXEC-cycle instruction, the expected branch outputs during that cycle
// and the expected flags/state after its edge. Interrupt entry/return,
// masked requests, idle EXEC cycles and reset during INTR are hand-written.
// ---------------------------------------------------------------------------
module tb_branch_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       INSTR_VALID;
  logic       COND_BRN;
  logic [1:0] COND_BRN_TYPE;
  logic       JMP;
  logic       CALL;
  logic       RET;
  logic       RETI;
  logic       INT_REQ;
  logic       C_IN;
  logic       Z_IN;
  logic       C_LD;
  logic       Z_LD;
  logic       C_SET;
  logic       C_CLR;
  logic       SEI;
  logic       CLI;
  logic       C_FLAG;
  logic       Z_FLAG;
  logic       I_FLAG;
  logic       PC_INC;
  logic       PC_LD;
  logic [1:0] PC_MUX_SEL;
  logic       INT_ACK;
  logic [1:0] STATE;

  int testCount;
  int failCount;

  // Stimulus mask bits
  localparam int unsigned M_V   = 32'h0001;
  localparam int unsigned M_CB  = 32'h0002;
  localparam int unsigned M_J   = 32'h0004;
  localparam int unsigned M_CA  = 32'h0008;
  localparam int unsigned M_R   = 32'h0010;
  localparam int unsigned M_RI  = 32'h0020;
  localparam int unsigned M_IQ  = 32'h0040;
  localparam int unsigned M_CI  = 32'h0080;
  localparam int unsigned M_ZI  = 32'h0100;
  localparam int unsigned M_CL  = 32'h0200;
  localparam int unsigned M_ZL  = 32'h0400;
  localparam int unsigned M_CS  = 32'h0800;
  localparam int unsigned M_CC  = 32'h1000;
  localparam int unsigned M_SE  = 32'h2000;
  localparam int unsigned M_CLI = 32'h4000;

  typedef struct {
    string       name;
    int unsigned stim;
    logic [1:0]  condType;
    logic        expPcLd;
    logic [1:0]  expSel;
    logic [2:0]  expCzi;
    logic [1:0]  expState;
  } vec_t;

  vec_t vecs[$];

  branch_sequencer #(.INT_VEC_SEL(2'b10)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .INSTR_VALID   (INSTR_VALID),
    .COND_BRN      (COND_BRN),
    .COND_BRN_TYPE (COND_BRN_TYPE),
    .JMP           (JMP),
    .CALL          (CALL),
    .RET           (RET),
    .RETI          (RETI),
    .INT_REQ       (INT_REQ),
    .C_IN          (C_IN),
    .Z_IN          (Z_IN),
    .C_LD          (C_LD),
    .Z_LD          (Z_LD),
    .C_SET         (C_SET),
    .C_CLR         (C_CLR),
    .SEI           (SEI),
    .CLI           (CLI),
    .C_FLAG        (C_FLAG),
    .Z_FLAG        (Z_FLAG),
    .I_FLAG        (I_FLAG),
    .PC_INC        (PC_INC),
    .PC_LD         (PC_LD),
    .PC_MUX_SEL    (PC_MUX_SEL),
    .INT_ACK       (INT_ACK),
    .STATE         (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(input string name, input int unsigned stim,
                                 input logic [1:0] condType, input logic expPcLd,
                                 input logic [1:0] expSel, input logic [2:0] expCzi,
                                 input logic [1:0] expState);
    vec_t v;
    v.name     = name;
    v.stim     = stim;
    v.condType = condType;
    v.expPcLd  = expPcLd;
    v.expSel   = expSel;
    v.expCzi   = expCzi;
    v.expState = expState;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input int unsigned m, input logic [1:0] condType);
    INSTR_VALID   = (m & M_V)   != 0;
    COND_BRN      = (m & M_CB)  != 0;
    COND_BRN_TYPE = condType;
    JMP           = (m & M_J)   != 0;
    CALL          = (m & M_CA)  != 0;
    RET           = (m & M_R)   != 0;
    RETI          = (m & M_RI)  != 0;
    INT_REQ       = (m & M_IQ)  != 0;
    C_IN          = (m & M_CI)  != 0;
    Z_IN          = (m & M_ZI)  != 0;
    C_LD          = (m & M_CL)  != 0;
    Z_LD          = (m & M_ZL)  != 0;
    C_SET         = (m & M_CS)  != 0;
    C_CLR         = (m & M_CC)  != 0;
    SEI           = (m & M_SE)  != 0;
    CLI           = (m & M_CLI) != 0;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] actual,
                             input logic [2:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Advance (at posedge+1 granularity) until the sequencer sits in EXEC
  task automatic waitExec();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (STATE == 2'b01) begin
        found = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    if (!found) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL waitExec: got state %b, expected 01 within 8 cycles", STATE);
    end
  endtask

  // One instruction: outputs checked mid-EXEC, flags/state after the edge
  task automatic runVector(input vec_t v);
    waitExec();
    applyStimulus(v.stim, v.condType);
    #1;
    checkOutput({v.name, ".pcLd"},   3'(PC_LD),      3'(v.expPcLd));
    checkOutput({v.name, ".sel"},    3'(PC_MUX_SEL), 3'(v.expSel));
    checkOutput({v.name, ".pcInc"},  3'(PC_INC),     3'b000);
    checkOutput({v.name, ".intAck"}, 3'(INT_ACK),    3'b000);
    @(posedge CLK);
    #1;
    applyStimulus(0, 2'b00);
    checkOutput({v.name, ".czi"},   {C_FLAG, Z_FLAG, I_FLAG}, v.expCzi);
    checkOutput({v.name, ".state"}, 3'(STATE),                3'(v.expState));
  endtask

  task automatic runOne(input string name, input int unsigned stim,
                        input logic [1:0] condType, input logic expPcLd,
                        input logic [1:0] expSel, input logic [2:0] expCzi,
                        input logic [1:0] expState);
    vec_t v;
    v.name     = name;
    v.stim     = stim;
    v.condType = condType;
    v.expPcLd  = expPcLd;
    v.expSel   = expSel;
    v.expCzi   = expCzi;
    v.expState = expState;
    runVector(v);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    RST_N = 1'b0;
    applyStimulus(0, 2'b00);

    // Flags evolve C,Z,I from 000 through the table in order
    addVec("noBranch",     M_V,                     2'b00, 1'b0, 2'b00, 3'b000, 2'b00);
    addVec("preset",       M_V|M_CS|M_ZL|M_ZI,      2'b00, 1'b0, 2'b00, 3'b110, 2'b00);
    addVec("retiCold",     M_V|M_RI,                2'b00, 1'b1, 2'b01, 3'b001, 2'b00);
    addVec("cli",          M_V|M_CLI,               2'b00, 1'b0, 2'b00, 3'b000, 2'b00);
    addVec("cLd",          M_V|M_CL|M_CI,           2'b00, 1'b0, 2'b00, 3'b100, 2'b00);
    addVec("brcsTaken",    M_V|M_CB,                2'b01, 1'b1, 2'b00, 3'b100, 2'b00);
    addVec("brccNotTaken", M_V|M_CB,                2'b00, 1'b0, 2'b00, 3'b100, 2'b00);
    addVec("breqOldZ",     M_V|M_CB|M_ZL|M_ZI,      2'b10, 1'b0, 2'b00, 3'b110, 2'b00);
    addVec("brneZ1",       M_V|M_CB,                2'b11, 1'b0, 2'b00, 3'b110, 2'b00);
    addVec("breqTaken",    M_V|M_CB,                2'b10, 1'b1, 2'b00, 3'b110, 2'b00);
    addVec("jmp",          M_V|M_J,                 2'b00, 1'b1, 2'b00, 3'b110, 2'b00);
    addVec("callOverCond", M_V|M_CA|M_CB,           2'b11, 1'b1, 2'b00, 3'b110, 2'b00);
    addVec("ret",          M_V|M_R,                 2'b00, 1'b1, 2'b01, 3'b110, 2'b00);
    addVec("retOverJmp",   M_V|M_R|M_J|M_CB,        2'b10, 1'b1, 2'b01, 3'b110, 2'b00);
    addVec("idleHold",     M_J|M_CC|M_ZL|M_SE|M_IQ, 2'b00, 1'b0, 2'b00, 3'b110, 2'b01);
    addVec("clrWins",      M_V|M_CC|M_CS|M_CL|M_CI, 2'b00, 1'b0, 2'b00, 3'b010, 2'b00);
    addVec("setWins",      M_V|M_CS|M_CL,           2'b00, 1'b0, 2'b00, 3'b110, 2'b00);
    addVec("cLdZero",      M_V|M_CL,                2'b00, 1'b0, 2'b00, 3'b010, 2'b00);
    addVec("brccTaken",    M_V|M_CB,                2'b00, 1'b1, 2'b00, 3'b010, 2'b00);
    addVec("brneOldZ",     M_V|M_CB|M_ZL,           2'b11, 1'b0, 2'b00, 3'b000, 2'b00);
    addVec("brneTaken",    M_V|M_CB,                2'b11, 1'b1, 2'b00, 3'b000, 2'b00);
    addVec("intMasked",    M_V|M_IQ,                2'b00, 1'b0, 2'b00, 3'b000, 2'b00);
    addVec("cliWins",      M_V|M_SE|M_CLI,          2'b00, 1'b0, 2'b00, 3'b000, 2'b00);
    addVec("seiSameCycle", M_V|M_SE|M_IQ,           2'b00, 1'b0, 2'b00, 3'b001, 2'b00);
    addVec("cliAgain",     M_V|M_CLI,               2'b00, 1'b0, 2'b00, 3'b000, 2'b00);

    // Reset state while RST_N is held low
    #2;
    checkOutput("rst.state",  3'(STATE),      3'b000);
    checkOutput("rst.czi",    {C_FLAG, Z_FLAG, I_FLAG}, 3'b000);
    checkOutput("rst.pcInc",  3'(PC_INC),     3'b000);
    checkOutput("rst.pcLd",   3'(PC_LD),      3'b000);
    checkOutput("rst.sel",    3'(PC_MUX_SEL), 3'b000);
    checkOutput("rst.intAck", 3'(INT_ACK),    3'b000);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checkOutput("fetch0.pcInc", 3'(PC_INC), 3'b001);
    checkOutput("fetch0.state", 3'(STATE),  3'b000);
    @(posedge CLK);
    #1;
    checkOutput("exec0.state", 3'(STATE),  3'b001);
    checkOutput("exec0.pcInc", 3'(PC_INC), 3'b000);

    foreach (vecs[i]) begin
      runVector(vecs[i]);
    end

    // Fetch/exec alternation with non-branching instructions
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("alt%0d.fetchInc", i), 3'(PC_INC), 3'b001);
      runOne($sformatf("alt%0d", i), M_V, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00);
    end

    // Interrupt entry with C=Z=1, then RETI after the flags were changed
    runOne("intSetup", M_V|M_CS|M_ZL|M_ZI|M_SE, 2'b00, 1'b0, 2'b00, 3'b111, 2'b00);
    runOne("intTrig",  M_V|M_IQ,                2'b00, 1'b0, 2'b00, 3'b111, 2'b10);
    checkOutput("intr.intAck", 3'(INT_ACK),    3'b001);
    checkOutput("intr.pcLd",   3'(PC_LD),      3'b001);
    checkOutput("intr.sel",    3'(PC_MUX_SEL), 3'b010);
    checkOutput("intr.pcInc",  3'(PC_INC),     3'b000);
    @(posedge CLK);
    #1;
    checkOutput("postIntr.state",  3'(STATE),   3'b000);
    checkOutput("postIntr.czi",    {C_FLAG, Z_FLAG, I_FLAG}, 3'b110);
    checkOutput("postIntr.intAck", 3'(INT_ACK), 3'b000);
    runOne("isrClr", M_V|M_CC|M_ZL,  2'b00, 1'b0, 2'b00, 3'b000, 2'b00);
    runOne("reti",   M_V|M_RI|M_CC,  2'b00, 1'b1, 2'b01, 3'b111, 2'b00);

    // Requests held while interrupts are disabled are never acknowledged
    runOne("maskCli", M_V|M_CLI, 2'b00, 1'b0, 2'b00, 3'b110, 2'b00);
    for (int i = 0; i < 10; i++) begin
      runOne($sformatf("masked%0d", i), M_V|M_IQ, 2'b00, 1'b0, 2'b00, 3'b110, 2'b00);
      checkOutput($sformatf("masked%0d.ack", i), 3'(INT_ACK), 3'b000);
    end

    // EXEC holds with no commands while no instruction is presented
    waitExec();
    applyStimulus(M_J|M_IQ|M_CS, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("idle%0d.out", i), {PC_INC, PC_LD, INT_ACK}, 3'b000);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("idle%0d.state", i), 3'(STATE), 3'b001);
    end
    applyStimulus(0, 2'b00);

    // Reset in the middle of an interrupt-entry cycle
    runOne("rstSei",  M_V|M_SE, 2'b00, 1'b0, 2'b00, 3'b111, 2'b00);
    runOne("rstTrig", M_V|M_IQ, 2'b00, 1'b0, 2'b00, 3'b111, 2'b10);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("midRst.out",   {PC_INC, PC_LD, INT_ACK}, 3'b000);
    checkOutput("midRst.sel",   3'(PC_MUX_SEL), 3'b000);
    checkOutput("midRst.state", 3'(STATE),      3'b000);
    checkOutput("midRst.czi",   {C_FLAG, Z_FLAG, I_FLAG}, 3'b000);
    #2;
    RST_N = 1'b1;
    #1;
    checkOutput("midRst.fetchInc", 3'(PC_INC), 3'b001);
    @(posedge CLK);
    #1;
    // Shadow was cleared, so RETI restores zeros
    runOne("retiAfterRst", M_V|M_RI, 2'b00, 1'b1, 2'b01, 3'b001, 2'b00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL have parameter INT_VEC_SEL, default 2'b10, the PC_MUX_SEL code that selects the interrupt vector.
REQ-002 The block SHALL have these ports:
- CLK  in  1  single system clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- INSTR_VALID  in  1  decoded instruction is present this cycle.
- COND_BRN  in  1  conditional-branch instruction.
- COND_BRN_TYPE  in  2  00 BRCC, 01 BRCS, 10 BREQ, 11 BRNE.
- JMP  in  1  unconditional jump.
- CALL  in  1  call.
- RET  in  1  return.
- RETI  in  1  return from interrupt.
- INT_REQ  in  1  level interrupt request.
- C_IN  in  1  ALU carry result.
- Z_IN  in  1  ALU zero result.
- C_LD  in  1  load C from C_IN.
- Z_LD  in  1  load Z from Z_IN.
- C_SET  in  1  set C.
- C_CLR  in  1  clear C.
- SEI  in  1  set I.
- CLI  in  1  clear I.
- C_FLAG  out  1  registered carry flag.
- Z_FLAG  out  1  registered zero flag.
- I_FLAG  out  1  registered interrupt enable.
- PC_INC  out  1  increment PC.
- PC_LD  out  1  load PC.
- PC_MUX_SEL  out  2  00 immediate, 01 stack, INT_VEC_SEL vector.
- INT_ACK  out  1  interrupt taken.
- STATE  out  2  current FSM state.

Function
REQ-003 The FSM SHALL have states FETCH=00, EXEC=01 and INTR=10; code 11 SHALL return to FETCH on the next edge and drive no commands.
REQ-004 In FETCH the block SHALL assert PC_INC for exactly one cycle and then go to EXEC.
REQ-005 In EXEC with INSTR_VALID=0 the block SHALL hold EXEC, assert no outputs, and leave all flags unchanged.
REQ-006 In EXEC with INSTR_VALID=1, branch priority SHALL be RET/RETI (PC_LD=1, SEL=01), then JMP/CALL (PC_LD=1, SEL=00), then COND_BRN (PC_LD=1, SEL=00 only if taken), else PC_LD=0.
REQ-007 A COND_BRN is taken when BRCC sees C=0, BRCS sees C=1, BREQ sees Z=1, or BRNE sees Z=0.
REQ-008 The branch-taken decision SHALL use the registered flag values from before this cycle's update.
REQ-009 All branch outputs are combinational from the state and inputs, with zero latency.
REQ-010 Flag updates SHALL apply only on the edge ending an EXEC cycle with INSTR_VALID=1.
REQ-011 C priority SHALL be RETI restore, then C_CLR, then C_SET, then C_LD.
REQ-012 Z priority SHALL be RETI restore, then Z_LD.
REQ-013 I priority SHALL be RETI (I<=1), then CLI, then SEI.
REQ-014 From a valid EXEC the next state SHALL be INTR if INT_REQ=1 and the pre-update I_FLAG=1, else FETCH; a SEI in the same cycle SHALL NOT enable the interrupt.
REQ-015 In INTR the block SHALL assert PC_LD=1, PC_MUX_SEL=INT_VEC_SEL and INT_ACK=1 for one cycle.
REQ-016 On the INTR edge: shadow_C<=C, shadow_Z<=Z, I<=0, with C and Z unchanged; the next state SHALL be FETCH.
REQ-017 INT_REQ SHALL be ignored in FETCH and INTR, and while I_FLAG=0; a request must be held by the requester until INT_ACK.
REQ-018 A RETI with no prior interrupt SHALL restore the shadow value, which is 0 after reset.

Reset
REQ-019 When RST_N goes low, state SHALL become FETCH and C, Z, I, shadow_C and shadow_Z SHALL become 0, asynchronously.
REQ-020 While RST_N=0, PC_INC, PC_LD, INT_ACK and PC_MUX_SEL SHALL be 0.
REQ-021 After reset is released, the first PC_INC SHALL appear in the first full FETCH cycle.
REQ-022 A reset asserted during INTR SHALL abort it: no INT_ACK, and shadow cleared.

Structure
REQ-023 The state enum, PC_MUX_SEL codes and COND_BRN_TYPE codes SHALL reside in shared package rat_pkg.
REQ-024 C, Z, I and the shadow registers with their priority logic SHALL be sub-module flag_unit; the FSM and branch decision SHALL stay in branch_sequencer.

Verification
REQ-025 Reset released, INSTR_VALID=1, no branch -> STATE 00,01,00,01..., PC_INC every other cycle.
REQ-026 C_LD=1, C_IN=1 in cycle N, then BRCS in the next EXEC -> PC_LD=1, SEL=00; BRCC with the same flags -> PC_LD=0.
REQ-027 In one EXEC: BREQ with Z=0 plus Z_LD=1, Z_IN=1 -> branch not taken, Z_FLAG=1 after the edge.
REQ-028 SEI executed, INT_REQ held, C=1, Z=1 -> next state INTR: INT_ACK=1, SEL=10, then I_FLAG=0; later RETI after C_CLR -> SEL=01, C=1, Z=1, I=1.
REQ-029 INT_REQ=1 with I=0 for 10 EXEC cycles -> INT_ACK never asserted; INSTR_VALID=0 for 3 cycles -> STATE stays 01, no outputs.
REQ-030 RST_N pulsed low mid-INTR -> outputs 0 immediately, flags and shadow 0, STATE=00.
